// File: rtl/object_pkg.sv
// Shared object identifiers, palette and SRAM layout for the sprite/map render pipeline.
// Optional `SPRITE_BBOX_DEBUG_EN adds a bounding-box flag to the sideband record.
package object_pkg;

   localparam int DEF_NUM_SPRITES = 2;
   localparam int DEF_SPRITE_SIZE = 32;
   localparam int DEF_MAP_W       = 640;
   localparam int DEF_MAP_H       = 480;
   localparam int DEF_ADDR_W      = 20;
   localparam int NUM_OBJECTS     = DEF_NUM_SPRITES + 1;

   localparam int MAP_WORDS = DEF_MAP_W * DEF_MAP_H / 4;
   localparam int SPR_WORDS = DEF_SPRITE_SIZE * DEF_SPRITE_SIZE / 4;

   typedef enum logic [1:0] {
      OBJECT_MAP     = 2'd0,
      OBJECT_SPRITE0 = 2'd1,
      OBJECT_SPRITE1 = 2'd2
   } ObjectID;

   typedef struct packed {
      logic       valid;
      ObjectID    obj;
      logic [1:0] sub;
`ifdef SPRITE_BBOX_DEBUG_EN
      logic       bbox;
`endif
   } sideband_t;

   // Map is grey, sprite 0 red, sprite 1 green; each scales with the 4-bit index.
   localparam logic [23:0] PALETTE [NUM_OBJECTS][16] = '{
      '{24'h000000, 24'h111111, 24'h222222, 24'h333333,
        24'h444444, 24'h555555, 24'h666666, 24'h777777,
        24'h888888, 24'h999999, 24'hAAAAAA, 24'hBBBBBB,
        24'hCCCCCC, 24'hDDDDDD, 24'hEEEEEE, 24'hFFFFFF},
      '{24'h000000, 24'h110000, 24'h220000, 24'h330000,
        24'h440000, 24'h550000, 24'h660000, 24'h770000,
        24'h880000, 24'h990000, 24'hAA0000, 24'hBB0000,
        24'hCC0000, 24'hDD0000, 24'hEE0000, 24'hFF0000},
      '{24'h000000, 24'h001100, 24'h002200, 24'h003300,
        24'h004400, 24'h005500, 24'h006600, 24'h007700,
        24'h008800, 24'h009900, 24'h00AA00, 24'h00BB00,
        24'h00CC00, 24'h00DD00, 24'h00EE00, 24'h00FF00}
   };

   localparam logic [23:0] BBOX_COLOR = 24'hFF00FF;

   function automatic logic [DEF_ADDR_W-1:0] sprite_base(input int unsigned k);
      return DEF_ADDR_W'(MAP_WORDS + k * SPR_WORDS);
   endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// Combinational hit test of one sprite against the current pixel: range, mask and local index.
// With `SPRITE_BBOX_DEBUG_EN an edge_o flag marks the sprite's bounding-box outline.
module sprite_hit_unit #(
   parameter int H_W         = 10,
   parameter int V_W         = 10,
   parameter int SPRITE_SIZE = 32,
   parameter int IDX_W       = 2 * $clog2(SPRITE_SIZE)
) (
   input  logic                               en_i,
   input  logic [H_W-1:0]                     h_i,
   input  logic [V_W-1:0]                     v_i,
   input  logic [H_W:0]                       x_i,    // two's complement
   input  logic [V_W:0]                       y_i,    // two's complement
   input  logic [SPRITE_SIZE*SPRITE_SIZE-1:0] mask_i,
   output logic                               hit_o,
`ifdef SPRITE_BBOX_DEBUG_EN
   output logic                               edge_o,
`endif
   output logic [IDX_W-1:0]                   idx_o
);

   localparam int S_W = $clog2(SPRITE_SIZE);

   logic [H_W+1:0] dx;
   logic [V_W+1:0] dy;
   logic           in_box;

   // Two extra bits keep the unsigned pixel minus signed origin free of wrap.
   assign dx = {2'b00, h_i} - {x_i[H_W], x_i};
   assign dy = {2'b00, v_i} - {y_i[V_W], y_i};

   // Power-of-two edge: 0 <= d < SPRITE_SIZE iff every bit above the local field is zero.
   assign in_box = (dx[H_W+1:S_W] == '0) && (dy[V_W+1:S_W] == '0);
   assign idx_o  = {dy[S_W-1:0], dx[S_W-1:0]};
   assign hit_o  = en_i && in_box && !mask_i[idx_o];

`ifdef SPRITE_BBOX_DEBUG_EN
   assign edge_o = en_i && in_box &&
                   ((dx[S_W-1:0] == '0) || (dx[S_W-1:0] == '1) ||
                    (dy[S_W-1:0] == '0) || (dy[S_W-1:0] == '1));
`endif

endmodule

// File: rtl/sprite_frame_pipeline.sv
// Per-pixel object select, SRAM word fetch and latency-aligned palette output stage.
// Optional `SPRITE_BBOX_DEBUG_EN paints enabled sprites' box outlines magenta.
module sprite_frame_pipeline
   import object_pkg::*;
#(
   parameter int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
   parameter int MAP_W       = DEF_MAP_W,
   parameter int SRAM_LAT    = 2,
   parameter int H_W         = 10,
   parameter int V_W         = 10,
   parameter int ADDR_W      = DEF_ADDR_W
) (
   input  logic                                           i_clk,
   input  logic                                           i_rst_n,
   input  logic                                           i_pix_valid,
   input  logic [H_W-1:0]                                 i_VGA_H,
   input  logic [V_W-1:0]                                 i_VGA_V,
   input  logic [NUM_SPRITES-1:0]                         i_sprite_en,
   input  logic [NUM_SPRITES*(H_W+1)-1:0]                 i_sprite_x,
   input  logic [NUM_SPRITES*(V_W+1)-1:0]                 i_sprite_y,
   input  logic [NUM_SPRITES*SPRITE_SIZE*SPRITE_SIZE-1:0] i_sprite_mask,
   output logic                                           o_sram_req,
   output logic [ADDR_W-1:0]                              o_sram_addr,
   input  logic [15:0]                                    i_sram_data,
   output logic [23:0]                                    o_color,
   output logic                                           o_color_valid
);

   localparam int IDX_W     = 2 * $clog2(SPRITE_SIZE);
   localparam int MASK_W    = SPRITE_SIZE * SPRITE_SIZE;
   localparam int MAP_IDX_W = $clog2(MAP_W * DEF_MAP_H);

   logic [NUM_SPRITES-1:0] hit;
   logic [IDX_W-1:0]       spr_idx [NUM_SPRITES];
`ifdef SPRITE_BBOX_DEBUG_EN
   logic [NUM_SPRITES-1:0] bbox_edge;
`endif

   for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
      sprite_hit_unit #(
         .H_W         (H_W),
         .V_W         (V_W),
         .SPRITE_SIZE (SPRITE_SIZE),
         .IDX_W       (IDX_W)
      ) u_hit (
         .en_i   (i_sprite_en[k]),
         .h_i    (i_VGA_H),
         .v_i    (i_VGA_V),
         .x_i    (i_sprite_x[k*(H_W+1) +: H_W+1]),
         .y_i    (i_sprite_y[k*(V_W+1) +: V_W+1]),
         .mask_i (i_sprite_mask[k*MASK_W +: MASK_W]),
         .hit_o  (hit[k]),
`ifdef SPRITE_BBOX_DEBUG_EN
         .edge_o (bbox_edge[k]),
`endif
         .idx_o  (spr_idx[k])
      );
   end

   logic [MAP_IDX_W-1:0] map_idx;
   assign map_idx = MAP_IDX_W'(i_VGA_V) * MAP_IDX_W'(MAP_W) + MAP_IDX_W'(i_VGA_H);

   logic              found;
   logic [ADDR_W-1:0] sram_addr_d, sram_addr_q;
   logic              sram_req_q;
   sideband_t         sb_d;

   // NOTE: every variable gets a default before the priority loop, so no latch is inferred.
   always_comb begin
      found       = 1'b0;
      sram_addr_d = ADDR_W'(map_idx >> 2);
      sb_d        = '0;
      sb_d.valid  = i_pix_valid;
      sb_d.obj    = OBJECT_MAP;
      sb_d.sub    = map_idx[1:0];
      for (int k = 0; k < NUM_SPRITES; k++) begin
         if (!found && hit[k]) begin
            found       = 1'b1;
            sb_d.obj    = ObjectID'(k + 1);
            sb_d.sub    = spr_idx[k][1:0];
            sram_addr_d = ADDR_W'(sprite_base(k)) + ADDR_W'(spr_idx[k] >> 2);
         end
      end
`ifdef SPRITE_BBOX_DEBUG_EN
      sb_d.bbox = |bbox_edge;
`endif
      if (!i_pix_valid) sb_d = '0;
   end

   // Entry SRAM_LAT lines up with the data word returned for the same pixel.
   sideband_t [SRAM_LAT:0] pipe_q;
   sideband_t              head;
   logic [3:0]             nibble;
   logic [23:0]            color_d, color_q;
   logic                   color_valid_q;

   assign head   = pipe_q[SRAM_LAT];
   assign nibble = i_sram_data[{head.sub, 2'b00} +: 4];

   always_comb begin
      color_d = '0;
      if (head.valid && (int'(head.obj) < NUM_OBJECTS)) color_d = PALETTE[head.obj][nibble];
`ifdef SPRITE_BBOX_DEBUG_EN
      if (head.valid && head.bbox) color_d = BBOX_COLOR;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sram_req_q    <= 1'b0;
         sram_addr_q   <= '0;
         // NOTE: the sideband pipe is control state, so it is reset; a data-only RAM would not be.
         pipe_q        <= '0;
         color_q       <= '0;
         color_valid_q <= 1'b0;
      end else begin
         sram_req_q <= i_pix_valid;
         if (i_pix_valid) sram_addr_q <= sram_addr_d;
         pipe_q        <= {pipe_q[SRAM_LAT-1:0], sb_d};
         color_q       <= color_d;
         color_valid_q <= head.valid;
      end
   end

   assign o_sram_req    = sram_req_q;
   assign o_sram_addr   = sram_addr_q;
   assign o_color       = color_q;
   assign o_color_valid = color_valid_q;

endmodule

// File: tb/tb_sprite_frame_pipeline.sv
// Directed bench: vector table for object select/address/colour, then streaming, latency and reset sequences.
// Two DUTs share stimulus: SRAM_LAT=2 (main) and SRAM_LAT=3 (latency rerun).
module tb_sprite_frame_pipeline;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pix_valid;
   logic [9:0]    vga_h, vga_v;
   logic [1:0]    sprite_en;
   logic [21:0]   sprite_x, sprite_y;
   logic [2047:0] sprite_mask;

   logic          req_a, req_b, cv_a, cv_b;
   logic [19:0]   addr_a, addr_b;
   logic [23:0]   color_a, color_b;
   logic [15:0]   data_a, data_b;
   logic [19:0]   a1, a2, b1, b2, b3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sprite_frame_pipeline #(.SRAM_LAT(2)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pix_valid),
      .i_VGA_H(vga_h), .i_VGA_V(vga_v), .i_sprite_en(sprite_en),
      .i_sprite_x(sprite_x), .i_sprite_y(sprite_y), .i_sprite_mask(sprite_mask),
      .o_sram_req(req_a), .o_sram_addr(addr_a), .i_sram_data(data_a),
      .o_color(color_a), .o_color_valid(cv_a)
   );

   sprite_frame_pipeline #(.SRAM_LAT(3)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pix_valid),
      .i_VGA_H(vga_h), .i_VGA_V(vga_v), .i_sprite_en(sprite_en),
      .i_sprite_x(sprite_x), .i_sprite_y(sprite_y), .i_sprite_mask(sprite_mask),
      .o_sram_req(req_b), .o_sram_addr(addr_b), .i_sram_data(data_b),
      .o_color(color_b), .o_color_valid(cv_b)
   );

   // SRAM model: nibble n of word A is A[3:0]+n+2, returned SRAM_LAT cycles after the address.
   function automatic logic [15:0] mem_word(input logic [19:0] a);
      logic [15:0] w;
      for (int n = 0; n < 4; n++) w[4*n +: 4] = a[3:0] + 4'(n) + 4'd2;
      return w;
   endfunction

   always @(posedge clk) begin
      a1 <= addr_a; a2 <= a1;
      b1 <= addr_b; b2 <= b1; b3 <= b2;
   end
   assign data_a = mem_word(a2);
   assign data_b = mem_word(b3);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          h, v;
      logic [1:0]  en;
      int          x0, y0, x1, y1;
      int          tmask0;     // sprite-0 transparent bit, -1 for none
      logic [19:0] exp_addr;
      logic [23:0] exp_color;
      logic        edge_f;     // pixel sits on an enabled sprite's box outline
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(input int h, v, input logic [1:0] en, input int x0, y0, x1, y1,
                               input int tm, input logic [19:0] ea, input logic [23:0] ec,
                               input logic ef);
      vec_t t;
      t.h = h; t.v = v; t.en = en; t.x0 = x0; t.y0 = y0; t.x1 = x1; t.y1 = y1;
      t.tmask0 = tm; t.exp_addr = ea; t.exp_color = ec; t.edge_f = ef;
      return t;
   endfunction

   task automatic drive_pixel(input int h, v, input logic valid);
      vga_h = 10'(h); vga_v = 10'(v); pix_valid = valid;
   endtask

   task automatic run_vec(input int i, input vec_t t);
      logic [23:0] ec;
      ec = t.exp_color;
`ifdef SPRITE_BBOX_DEBUG_EN
      if (t.edge_f) ec = 24'hFF00FF;
`endif
      @(negedge clk);
      sprite_en   = t.en;
      sprite_x    = {11'(t.x1), 11'(t.x0)};
      sprite_y    = {11'(t.y1), 11'(t.y0)};
      sprite_mask = '0;
      if (t.tmask0 >= 0) sprite_mask[t.tmask0] = 1'b1;
      drive_pixel(t.h, t.v, 1'b1);
      @(negedge clk);
      pix_valid = 1'b0;
      check($sformatf("vec%0d addr", i), 32'(addr_a), 32'(t.exp_addr));
      check($sformatf("vec%0d req", i), 32'(req_a), 32'd1);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d valid", i), 32'(cv_a), 32'd1);
      check($sformatf("vec%0d color", i), 32'(color_a), 32'(ec));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  pattern;
      logic [3:0]  nib;
      logic [23:0] exp_c;

      vecs[0]  = mk(3,   1,   2'b00, 0,   0,   0,   0,   -1,  20'd160,   24'h555555, 1'b0);
      vecs[1]  = mk(110, 60,  2'b01, 100, 50,  0,   0,   -1,  20'd76882, 24'h660000, 1'b0);
      vecs[2]  = mk(110, 60,  2'b11, 100, 50,  100, 50,  330, 20'd77138, 24'h006600, 1'b0);
      vecs[3]  = mk(0,   0,   2'b01, -5,  -5,  0,   0,   -1,  20'd76841, 24'hCC0000, 1'b0);
      vecs[4]  = mk(27,  0,   2'b01, -5,  -5,  0,   0,   -1,  20'd6,     24'hBBBBBB, 1'b0);
      vecs[5]  = mk(110, 60,  2'b11, 100, 50,  100, 50,  -1,  20'd76882, 24'h660000, 1'b0);
      vecs[6]  = mk(110, 60,  2'b00, 100, 50,  100, 50,  -1,  20'd9627,  24'hFFFFFF, 1'b0);
      vecs[7]  = mk(131, 81,  2'b01, 100, 50,  0,   0,   -1,  20'd77055, 24'h440000, 1'b1);
      vecs[8]  = mk(132, 81,  2'b01, 100, 50,  0,   0,   -1,  20'd12993, 24'h333333, 1'b0);
      vecs[9]  = mk(99,  60,  2'b01, 100, 50,  0,   0,   -1,  20'd9624,  24'hDDDDDD, 1'b0);
      vecs[10] = mk(600, 400, 2'b10, 100, 50,  600, 400, -1,  20'd77056, 24'h002200, 1'b1);
      vecs[11] = mk(100, 60,  2'b01, 100, 50,  0,   0,   -1,  20'd76880, 24'h220000, 1'b1);

      rst_n = 1'b0;
      sprite_en = '0; sprite_x = '0; sprite_y = '0; sprite_mask = '0;
      drive_pixel(0, 0, 1'b0);
      repeat (2) @(negedge clk);
      check("reset req", 32'(req_a), 32'd0);
      check("reset addr", 32'(addr_a), 32'd0);
      check("reset color", 32'(color_a), 32'd0);
      check("reset valid", 32'(cv_a), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Streaming: map pixels (8+i,0) with a gapped valid pattern through both latencies.
      repeat (3) @(negedge clk);
      sprite_en = '0;
      pattern = 8'b0110_1101;   // slot i uses bit i: 1,0,1,1,0,1,1,0
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         if (cyc >= 4 && cyc - 4 < 8) begin
            nib   = 4'((8 + cyc - 4) >> 2) + 4'((8 + cyc - 4) & 3) + 4'd2;
            exp_c = pattern[cyc-4] ? {6{nib}} : 24'h0;
            check($sformatf("lat2 slot%0d valid", cyc - 4), 32'(cv_a), 32'(pattern[cyc-4]));
            check($sformatf("lat2 slot%0d color", cyc - 4), 32'(color_a), 32'(exp_c));
         end
         if (cyc >= 5 && cyc - 5 < 8) begin
            nib   = 4'((8 + cyc - 5) >> 2) + 4'((8 + cyc - 5) & 3) + 4'd2;
            exp_c = pattern[cyc-5] ? {6{nib}} : 24'h0;
            check($sformatf("lat3 slot%0d valid", cyc - 5), 32'(cv_b), 32'(pattern[cyc-5]));
            check($sformatf("lat3 slot%0d color", cyc - 5), 32'(color_b), 32'(exp_c));
         end
         if (cyc < 8) drive_pixel(8 + cyc, 0, pattern[cyc]);
         else         drive_pixel(0, 0, 1'b0);
      end

      // Reset mid-stream: outputs clear at once and nothing in flight survives.
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         drive_pixel(20 + cyc, 2, 1'b1);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst req", 32'(req_a), 32'd0);
      check("midrst addr", 32'(addr_a), 32'd0);
      check("midrst color", 32'(color_a), 32'd0);
      check("midrst valid", 32'(cv_a), 32'd0);
      check("midrst valid lat3", 32'(cv_b), 32'd0);
      drive_pixel(0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         check($sformatf("postrst idle%0d valid", cyc), 32'(cv_a), 32'd0);
      end

      // First pixel after reset appears exactly four cycles later.
      drive_pixel(3, 1, 1'b1);
      @(negedge clk);
      pix_valid = 1'b0;
      check("postrst addr", 32'(addr_a), 32'd160);
      repeat (2) @(negedge clk);
      check("postrst early valid", 32'(cv_a), 32'd0);
      @(negedge clk);
      check("postrst valid", 32'(cv_a), 32'd1);
      check("postrst color", 32'(color_a), 32'h555555);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
